// File: rtl/cy_stream_packer.sv
// Narrow-to-wide stream packer: gathers RATIO DW-bit beats into one registered
// word with a lane keep mask, flushing early on a packet-last beat.
module cy_stream_packer #(
    parameter int DW    = 8,
    parameter int RATIO = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DW-1:0]       i_data,
    input  logic                i_last,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DW*RATIO-1:0] o_data,
    output logic [RATIO-1:0]    o_keep,
    output logic                o_last
);
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int WW = DW * RATIO;

    logic [CW-1:0]           cnt_r;
    logic [DW*(RATIO-1)-1:0] acc_r;
    logic                    acc_en_s;
    logic                    complete_s;
    logic                    drain_s;
    logic [WW-1:0]           lanes_s;
    logic [WW-1:0]           word_s;
    logic [RATIO-1:0]        keep_s;

    // The top lane never lives in acc; padding it lets every lane be indexed uniformly.
    assign lanes_s    = {{DW{1'b0}}, acc_r};
    assign o_ready    = !o_valid || i_ready;
    assign acc_en_s   = i_valid && o_ready;
    assign complete_s = acc_en_s && ((cnt_r == CW'(RATIO - 1)) || i_last);
    assign drain_s    = o_valid && i_ready;

    // Assemble the word that a completing beat would load: stored lanes, current beat, zeros above.
    always_comb begin
        word_s = '0;
        keep_s = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (CW'(l) < cnt_r) begin
                word_s[l*DW +: DW] = lanes_s[l*DW +: DW];
                keep_s[l]          = 1'b1;
            end else if (CW'(l) == cnt_r) begin
                word_s[l*DW +: DW] = i_data;
                keep_s[l]          = 1'b1;
            end else begin
                word_s[l*DW +: DW] = {DW{1'b0}};
                keep_s[l]          = 1'b0;
            end
        end
    end

    // Lane accumulation and registered output word; a completing beat overrides a drain.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_r   <= '0;
            acc_r   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
        end else if (complete_s) begin
            o_data  <= word_s;
            o_keep  <= keep_s;
            o_last  <= i_last;
            o_valid <= 1'b1;
            cnt_r   <= '0;
            acc_r   <= '0;
        end else begin
            if (acc_en_s) begin
                for (int l = 0; l < RATIO - 1; l++) begin
                    if (CW'(l) == cnt_r) begin
                        acc_r[l*DW +: DW] <= i_data;
                    end
                end
                cnt_r <= cnt_r + CW'(1);
            end
            if (drain_s) begin
                o_valid <= 1'b0;
            end
        end
    end

    cy_stream_packer_chk #(
        .DW    (DW),
        .RATIO (RATIO)
    ) u_chk (
        .clk     (i_clk),
        .rst     (i_reset),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last)
    );
endmodule

// Protocol checker: held output under back-pressure and a contiguous keep mask from lane 0.
module cy_stream_packer_chk #(
    parameter int DW    = 8,
    parameter int RATIO = 4
) (
    input logic                clk,
    input logic                rst,
    input logic                o_valid,
    input logic                i_ready,
    input logic                o_ready,
    input logic [DW*RATIO-1:0] o_data,
    input logic [RATIO-1:0]    o_keep,
    input logic                o_last
);
    logic stall_s;
    logic [RATIO-1:0] keep_inc_s;

    assign stall_s    = o_valid && !i_ready;
    assign keep_inc_s = o_keep + RATIO'(1);

    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        stall_s |=> (o_valid && $stable(o_data) && $stable(o_keep) && $stable(o_last)));

    a_ready_rule: assert property (@(posedge clk) disable iff (rst)
        o_ready == (!o_valid || i_ready));

    a_keep_shape: assert property (@(posedge clk) disable iff (rst)
        o_valid |-> (o_keep[0] && ((o_keep & keep_inc_s) == '0)));
endmodule

// File: tb/tb_cy_stream_packer.sv
// Scoreboard bench for cy_stream_packer (DW=8, RATIO=4): directed packets,
// back-pressure and asynchronous reset.
module tb_cy_stream_packer;
    localparam int DW    = 8;
    localparam int RATIO = 4;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_valid;
    logic               o_ready;
    logic [DW-1:0]      i_data;
    logic               i_last;
    logic               o_valid;
    logic               i_ready;
    logic [DW*RATIO-1:0] o_data;
    logic [RATIO-1:0]   o_keep;
    logic               o_last;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    cy_stream_packer #(.DW(DW), .RATIO(RATIO)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Present one beat and return just after the edge that accepts it.
    task automatic send(input logic [7:0] d, input logic l, output int stalls);
        stalls  = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        @(negedge i_clk);
        while (!o_ready && stalls < 100) begin
            stalls++;
            @(negedge i_clk);
        end
        if (stalls >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout beat=0x%02h", d);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Monitor: a word that is valid with ready high is consumed at the next edge.
    always @(negedge i_clk) begin
        if (!i_reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=0x%08h expected=none", o_data);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                chk("sb_data", o_data, w.data);
                chk("sb_keep", {28'd0, o_keep}, {28'd0, w.keep});
                chk("sb_last", {31'd0, o_last}, {31'd0, w.last});
            end
        end
    end

    initial begin
        int st;
        int stall_sum;
        logic [7:0] b;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_last  = 1'b0;
        i_ready = 1'b1;
        #2;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_keep", {28'd0, o_keep}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        #20;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // Full word with latency and drop checks
        push(32'h44332211, 4'b1111, 1'b0);
        send(8'h11, 1'b0, st);
        send(8'h22, 1'b0, st);
        send(8'h33, 1'b0, st);
        chk("full_not_yet", {31'd0, o_valid}, 32'd0);
        send(8'h44, 1'b0, st);
        chk("full_valid", {31'd0, o_valid}, 32'd1);
        chk("full_data", o_data, 32'h44332211);
        @(posedge i_clk);
        #1;
        chk("full_drop", {31'd0, o_valid}, 32'd0);

        // Short packet, then single-beat packet starting in lane 0
        push(32'h0000BBAA, 4'b0011, 1'b1);
        send(8'hAA, 1'b0, st);
        send(8'hBB, 1'b1, st);
        push(32'h0000005A, 4'b0001, 1'b1);
        send(8'h5A, 1'b1, st);

        // Back-pressure on a presented word while 0x01 waits upstream
        push(32'hD4C3B2A1, 4'b1111, 1'b0);
        send(8'hA1, 1'b0, st);
        send(8'hB2, 1'b0, st);
        send(8'hC3, 1'b0, st);
        send(8'hD4, 1'b0, st);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h01;
        i_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
            chk("bp_hold", o_data, 32'hD4C3B2A1);
        end
        @(posedge i_clk);
        #1;
        push(32'h04030201, 4'b1111, 1'b0);
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        send(8'h02, 1'b0, st);
        send(8'h03, 1'b0, st);
        send(8'h04, 1'b0, st);

        // Back-to-back packets with no ready drop
        push(32'h04030201, 4'b1111, 1'b0);
        push(32'h08070605, 4'b1111, 1'b1);
        stall_sum = 0;
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            send(b, (i == 8), st);
            stall_sum += st;
        end
        chk("b2b_no_stall", 32'(stall_sum), 32'd0);
        @(posedge i_clk);
        #1;

        // Asynchronous reset between edges while 0x10, 0x20 are stored
        send(8'h10, 1'b0, st);
        send(8'h20, 1'b0, st);
        #3;
        i_reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_data", o_data, 32'd0);
        chk("arst_keep", {28'd0, o_keep}, 32'd0);
        chk("arst_last", {31'd0, o_last}, 32'd0);
        #2;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        push(32'h60504030, 4'b1111, 1'b0);
        send(8'h30, 1'b0, st);
        send(8'h40, 1'b0, st);
        send(8'h50, 1'b0, st);
        send(8'h60, 1'b0, st);

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(posedge i_clk);
        end
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
